ixc_skid_slice: RTL and testbench

//  Registered valid/ready slice (2-entry skid buffer) on the wide emulation bus.
//  Its out_data feeds the bit-wise assign stage, ixc_assign_106 (R input).

---
 rtl/ixc_skid_pkg.sv | 13 +
 rtl/ixc_sat_counter.sv | 50 +++++
 rtl/ixc_skid_slice.sv | 108 ++++++++++
 tb/tb_ixc_skid_slice.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ixc_skid_pkg.sv
// Shared types and widths for the emulation-bus skid slice.
// The state encoding is also visible to anything probing the slice for debug.
package ixc_skid_pkg;

  localparam int IXC_BUS_W = 106;

  typedef enum logic [1:0] {
    SK_EMPTY,
    SK_BUSY,
    SK_FULL
  } sk_state_t;

endpackage

// File: rtl/ixc_sat_counter.sv
// Saturating event counter with a sticky all-ones flag; clear beats increment.
// Latency: cnt/ovf update on the edge after inc/clr; no backpressure.
module ixc_sat_counter
  import ixc_skid_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_q;
  logic             ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_MAX) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/ixc_skid_slice.sv
// Two-entry registered valid/ready slice: 1-cycle latency, 1 beat/cycle.
// in_ready is a flop, so a stalled beat lands in skid_q instead of being lost.
module ixc_skid_slice
  import ixc_skid_pkg::*;
#(
  parameter int WIDTH = IXC_BUS_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             ovf
);

  sk_state_t        state_q;
  sk_state_t        state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             load_main;
  logic             load_skid;
  logic             main_from_skid;

  assign out_valid = (state_q != SK_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      SK_EMPTY: begin
        if (in_xfer) begin
          state_d   = SK_BUSY;
          load_main = 1'b1;
        end
      end
      SK_BUSY: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          // Downstream stalled while ready was already promised upstream.
          state_d   = SK_FULL;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = SK_EMPTY;
        end
      end
      SK_FULL: begin
        if (out_xfer) begin
          state_d        = SK_BUSY;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = SK_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SK_EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != SK_FULL);
      if (load_main) begin
        main_q <= main_from_skid ? skid_q : in_data;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  ixc_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(out_valid & ~out_ready),
    .clr(stall_clr),
    .cnt(stall_cnt),
    .ovf(ovf)
  );

  a_full_from_busy: assert property (@(posedge clk) disable iff (rst)
    (state_d == SK_FULL && state_q != SK_FULL) |-> (state_q == SK_BUSY));

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_ixc_skid_slice.sv
// Directed and random stimulus for ixc_skid_slice; a negedge monitor checks
// every delivered beat against a queue filled when the slice accepts a beat.
module tb_ixc_skid_slice;
  import ixc_skid_pkg::*;

  localparam int W  = IXC_BUS_W;
  localparam int CW = 4;
  localparam logic [W-1:0] VA = W'(128'h0123_4567_89ab_cdef_0011_2233_4455);
  localparam logic [W-1:0] VB = W'(128'h3fed_cba9_8765_4321_ffee_ddcc_bbaa);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          stall_clr;
  logic [CW-1:0] stall_cnt;
  logic          ovf;

  int            n_checks = 0;
  int            n_fail = 0;
  int            n_pushed = 0;
  int            n_popped = 0;
  logic [W-1:0]  exp_q[$];
  logic          last_acc;
  logic [127:0]  rnd;
  int            sent;
  int            cyc;

  always #5 clk = ~clk;

  ixc_skid_slice #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .stall_clr(stall_clr),
    .stall_cnt(stall_cnt),
    .ovf(ovf)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: note acceptance at negedge, then return 1 time unit after posedge.
  task automatic step();
    @(negedge clk);
    last_acc = in_valid && in_ready && !rst;
    if (rst) begin
      exp_q.delete();
    end else if (last_acc) begin
      exp_q.push_back(in_data);
      n_pushed++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: order/content of delivered beats and stability of held beats.
  initial begin : monitor
    logic         hold_prev;
    logic [W-1:0] data_prev;
    logic [W-1:0] e;
    hold_prev = 1'b0;
    data_prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          check("hold_valid", W'(out_valid), W'(1));
          check("hold_data", out_data, data_prev);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h expected no beat", out_data);
          end else begin
            e = exp_q.pop_front();
            check("beat_order", out_data, e);
            n_popped++;
          end
        end
        hold_prev = out_valid && !out_ready;
        data_prev = out_data;
      end
    end
  end

  initial begin : stimulus
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = W'(128'hdead_beef);
    out_ready = 1'b1;
    stall_clr = 1'b0;
    last_acc  = 1'b0;

    // Reset state, with a beat offered that must be dropped.
    step();
    step();
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_out_data", out_data, W'(0));
    check("rst_stall_cnt", W'(stall_cnt), W'(0));
    check("rst_ovf", W'(ovf), W'(0));
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    check("post_rst_in_ready", W'(in_ready), W'(1));
    check("post_rst_no_beat", W'(out_valid), W'(0));

    // Single beat, 1-cycle latency.
    in_valid = 1'b1;
    in_data  = W'(1);
    step();
    check("t1_accept", W'(last_acc), W'(1));
    check("t1_out_valid", W'(out_valid), W'(1));
    check("t1_out_data", out_data, W'(1));
    check("t1_in_ready", W'(in_ready), W'(1));
    in_valid = 1'b0;
    step();
    check("t1_empty", W'(out_valid), W'(0));

    // Streaming 0..99 at full rate.
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      step();
      check("t2_accept", W'(last_acc), W'(1));
      check("t2_out_valid", W'(out_valid), W'(1));
      check("t2_out_data", out_data, W'(i));
    end
    in_valid = 1'b0;
    step();
    check("t2_empty", W'(out_valid), W'(0));

    // Fill both entries under backpressure, then drain.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = VA;
    step();
    check("t3_accept_a", W'(last_acc), W'(1));
    check("t3_busy_ready", W'(in_ready), W'(1));
    in_data = VB;
    step();
    check("t3_accept_b", W'(last_acc), W'(1));
    check("t3_state_full", W'(dut.state_q), W'(SK_FULL));
    check("t3_full_ready", W'(in_ready), W'(0));
    check("t3_full_data", out_data, VA);
    in_valid = 1'b0;
    step();
    check("t3_hold_data", out_data, VA);
    check("t3_hold_ready", W'(in_ready), W'(0));
    out_ready = 1'b1;
    step();
    check("t3_second_valid", W'(out_valid), W'(1));
    check("t3_second_data", out_data, VB);
    check("t3_second_ready", W'(in_ready), W'(1));
    step();
    check("t3_drained", W'(out_valid), W'(0));

    // Random valid/ready for 10k beats.
    sent     = 0;
    cyc      = 0;
    last_acc = 1'b0;
    in_valid = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      if (!in_valid || last_acc) begin
        in_valid = 1'($urandom_range(0, 1));
        rnd      = {$urandom, $urandom, $urandom, $urandom};
        in_data  = rnd[W-1:0];
      end
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (last_acc) sent++;
      cyc++;
    end
    check("t4_sent", W'(sent), W'(10000));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("t4_drain_empty", W'(exp_q.size()), W'(0));
    check("t4_push_pop", W'(n_popped), W'(n_pushed));

    // Reset while full discards both entries.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(128'hc0c0);
    step();
    in_data = W'(128'hd0d0);
    step();
    check("t5_full", W'(dut.state_q), W'(SK_FULL));
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_valid", W'(out_valid), W'(0));
    check("t5_rst_ready", W'(in_ready), W'(0));
    check("t5_rst_data", out_data, W'(0));
    check("t5_rst_cnt", W'(stall_cnt), W'(0));
    check("t5_rst_ovf", W'(ovf), W'(0));
    out_ready = 1'b1;
    step();
    check("t5_ready_back", W'(in_ready), W'(1));
    check("t5_no_stale", W'(out_valid), W'(0));
    step();
    check("t5_no_stale2", W'(out_valid), W'(0));

    // Stall counter saturation and clear-beats-increment.
    stall_clr = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(128'he0e0);
    step();
    stall_clr = 1'b0;
    in_valid  = 1'b0;
    check("t6_cnt_start", W'(stall_cnt), W'(0));
    repeat (10) step();
    check("t6_cnt_10", W'(stall_cnt), W'(10));
    check("t6_ovf_10", W'(ovf), W'(0));
    repeat (4) step();
    check("t6_cnt_14", W'(stall_cnt), W'(14));
    check("t6_ovf_14", W'(ovf), W'(0));
    step();
    check("t6_cnt_15", W'(stall_cnt), W'(15));
    check("t6_ovf_15", W'(ovf), W'(1));
    repeat (5) step();
    check("t6_cnt_sat", W'(stall_cnt), W'(15));
    check("t6_ovf_sat", W'(ovf), W'(1));
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    check("t6_clr_cnt", W'(stall_cnt), W'(0));
    check("t6_clr_ovf", W'(ovf), W'(0));
    step();
    check("t6_recount", W'(stall_cnt), W'(1));
    out_ready = 1'b1;
    step();
    check("t6_drained", W'(out_valid), W'(0));
    check("final_queue_empty", W'(exp_q.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
